// File: rtl/egress_rr_scheduler.sv
// Per-egress-port round-robin scheduler: picks one ingress requester whose
//   head packet targets PORT_ID, then moves exactly XFER_WORDS words from it
//   into the egress buffer, then holds an idle gap of GAP_CYCLES cycles.
// Latency: grant one cycle after the IDLE decision; first write one cycle after grant.
// Backpressure: egress_full only blocks new grants; a started transfer never stalls.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   req[i]            requester i has a head packet; its current word is on data_in slice i
//   req_dest[2i+1:2i] destination port of requester i's head packet
//   data_in           NUM_PORTS words of DATA_WIDTH, slice i = requester i
//   egress_full       egress buffer full, suppresses new grants
//   grant             registered one-hot, high for the whole transfer
//   word_ack          combinational pop to the current requester during XFER
//   write_en/data_out registered write port into the egress buffer
//   pkt_done          pulse coincident with the last write of a packet
//   cur_src           index of the current or most recent granted requester
//   pkt_count         packets completed since reset, wrapping 16-bit count

module egress_rr_scheduler #(
  parameter int NUM_PORTS  = 4,
  parameter int PORT_ID    = 0,
  parameter int DATA_WIDTH = 32,
  parameter int XFER_WORDS = 6,
  parameter int GAP_CYCLES = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_PORTS-1:0]             req,
  input  logic [2*NUM_PORTS-1:0]           req_dest,
  input  logic [DATA_WIDTH*NUM_PORTS-1:0]  data_in,
  input  logic                             egress_full,
  output logic [NUM_PORTS-1:0]             grant,
  output logic [NUM_PORTS-1:0]             word_ack,
  output logic                             write_en,
  output logic [DATA_WIDTH-1:0]            data_out,
  output logic                             pkt_done,
  output logic [1:0]                       cur_src,
  output logic [15:0]                      pkt_count
);

  localparam int WCW = (XFER_WORDS > 1) ? $clog2(XFER_WORDS) : 1;
  localparam int GCW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [WCW-1:0] WORD_LAST = WCW'(XFER_WORDS - 1);
  localparam logic [GCW-1:0] GAP_LAST  = GCW'(GAP_CYCLES - 1);
  localparam logic [1:0]     PORT_SEL  = 2'(PORT_ID);
  // Reset value of last_grant makes requester 0 the first in line.
  localparam logic [1:0]     LAST_INIT = 2'(NUM_PORTS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [WCW-1:0]          word_cnt_q, word_cnt_d;
  logic [GCW-1:0]          gap_cnt_q, gap_cnt_d;
  logic [1:0]              last_grant_q, last_grant_d;
  logic [NUM_PORTS-1:0]    grant_q, grant_d;
  logic [1:0]              cur_src_q, cur_src_d;
  logic                    write_en_q, write_en_d;
  logic [DATA_WIDTH-1:0]   data_out_q, data_out_d;
  logic                    pkt_done_q, pkt_done_d;
  logic [15:0]             pkt_count_q, pkt_count_d;

  // Eligibility padded to 4 bits so a 2-bit index is always in range.
  logic [3:0]              elig;
  logic [1:0]              cand;
  logic                    pick_vld;
  logic [1:0]              pick_idx;
  logic [DATA_WIDTH-1:0]   sel_word;

  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      elig[i] = req[i] && (req_dest[2*i +: 2] == PORT_SEL);
    end
  end

  // Search starts just after the last winner, so the winner drops to the
  // lowest priority for the next decision.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      cand = 2'((int'(last_grant_q) + k) % NUM_PORTS);
      if (!pick_vld && elig[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  always_comb begin
    sel_word = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (cur_src_q == 2'(i)) begin
        sel_word = data_in[DATA_WIDTH*i +: DATA_WIDTH];
      end
    end
  end

  // Pop is tied to the state, not to req: once a transfer starts the
  // requester is drained for XFER_WORDS words regardless of its inputs.
  always_comb begin
    word_ack = '0;
    if (state_q == ST_XFER) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (cur_src_q == 2'(i)) begin
          word_ack[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    word_cnt_d   = word_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    cur_src_d    = cur_src_q;
    write_en_d   = 1'b0;
    data_out_d   = data_out_q;
    pkt_done_d   = 1'b0;
    pkt_count_d  = pkt_count_q;

    case (state_q)
      ST_IDLE: begin
        if (pick_vld && !egress_full) begin
          grant_d      = '0;
          for (int i = 0; i < NUM_PORTS; i++) begin
            if (pick_idx == 2'(i)) begin
              grant_d[i] = 1'b1;
            end
          end
          cur_src_d    = pick_idx;
          last_grant_d = pick_idx;
          word_cnt_d   = '0;
          state_d      = ST_XFER;
        end
      end

      ST_XFER: begin
        data_out_d = sel_word;
        write_en_d = 1'b1;
        word_cnt_d = word_cnt_q + 1'b1;
        if (word_cnt_q == WORD_LAST) begin
          pkt_done_d  = 1'b1;
          pkt_count_d = pkt_count_q + 16'd1;
          grant_d     = '0;
          gap_cnt_d   = '0;
          word_cnt_d  = '0;
          state_d     = ST_GAP;
        end
      end

      ST_GAP: begin
        // Gives the downstream metadata extractor time to commit the packet.
        if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d = '0;
          state_d   = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end

      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      word_cnt_q   <= '0;
      gap_cnt_q    <= '0;
      last_grant_q <= LAST_INIT;
      grant_q      <= '0;
      cur_src_q    <= '0;
      write_en_q   <= 1'b0;
      data_out_q   <= '0;
      pkt_done_q   <= 1'b0;
      pkt_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      word_cnt_q   <= word_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      cur_src_q    <= cur_src_d;
      write_en_q   <= write_en_d;
      data_out_q   <= data_out_d;
      pkt_done_q   <= pkt_done_d;
      pkt_count_q  <= pkt_count_d;
    end
  end

  assign grant     = grant_q;
  assign write_en  = write_en_q;
  assign data_out  = data_out_q;
  assign pkt_done  = pkt_done_q;
  assign cur_src   = cur_src_q;
  assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_egress_rr_scheduler.sv
// Bench for egress_rr_scheduler: directed scenario tasks plus a randomized run
// checked against a transaction-level timing model of the scheduler.
module tb_egress_rr_scheduler;
  localparam int NP  = 4;
  localparam int PID = 0;
  localparam int DW  = 32;
  localparam int XW  = 6;
  localparam int GC  = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [NP-1:0]   req;
  logic [2*NP-1:0] req_dest;
  logic [DW*NP-1:0] data_in;
  logic            egress_full;
  logic [NP-1:0]   grant;
  logic [NP-1:0]   word_ack;
  logic            write_en;
  logic [DW-1:0]   data_out;
  logic            pkt_done;
  logic [1:0]      cur_src;
  logic [15:0]     pkt_count;

  egress_rr_scheduler #(
    .NUM_PORTS(NP), .PORT_ID(PID), .DATA_WIDTH(DW), .XFER_WORDS(XW), .GAP_CYCLES(GC)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .req_dest(req_dest), .data_in(data_in),
    .egress_full(egress_full), .grant(grant), .word_ack(word_ack), .write_en(write_en),
    .data_out(data_out), .pkt_done(pkt_done), .cur_src(cur_src), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  int          runs = 0;
  int          fails = 0;
  logic [3:0]  ack_s;
  int          wptr[4];
  logic [31:0] base[4];

  // Requester i presents base[i] + (words popped so far).
  task automatic drive_data();
    for (int i = 0; i < NP; i++) data_in[DW*i +: DW] = base[i] + 32'(wptr[i]);
  endtask

  // Advance one cycle; returns at the falling edge with outputs settled.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < NP; i++) if (ack_s[i]) wptr[i]++;
    drive_data();
    @(negedge clk);
    ack_s = word_ack;
  endtask

  task automatic do_reset();
    reset = 1'b1; req = '0; req_dest = '0; egress_full = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < NP; i++) begin
      wptr[i] = 0;
      base[i] = {8'(i), 24'h0};
    end
    ack_s = '0;
    drive_data();
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 4'hF; req_dest = '0; egress_full = 1'b0;
    tick();
    tick();
    runs++; if (grant !== 4'b0) begin fails++; $display("FAIL reset_grant: got %b expected 0000", grant); end
    runs++; if (word_ack !== 4'b0) begin fails++; $display("FAIL reset_word_ack: got %b expected 0000", word_ack); end
    runs++; if (write_en !== 1'b0) begin fails++; $display("FAIL reset_write_en: got %b expected 0", write_en); end
    runs++; if (pkt_done !== 1'b0) begin fails++; $display("FAIL reset_pkt_done: got %b expected 0", pkt_done); end
    runs++; if (data_out !== 32'h0) begin fails++; $display("FAIL reset_data_out: got %h expected 0", data_out); end
    runs++; if (cur_src !== 2'd0) begin fails++; $display("FAIL reset_cur_src: got %0d expected 0", cur_src); end
    runs++; if (pkt_count !== 16'd0) begin fails++; $display("FAIL reset_pkt_count: got %0d expected 0", pkt_count); end
    reset = 1'b0; req = 4'b1001;
    tick();
    runs++; if (grant !== 4'b0001) begin fails++; $display("FAIL reset_first_priority: got %b expected 0001", grant); end
  endtask

  task automatic test_single();
    logic [3:0] eg;
    logic ew, ed;
    do_reset();
    base[0] = 32'hA0; drive_data();
    req = 4'b0001; req_dest = 8'h00;
    for (int c = 1; c <= XW + GC + 2; c++) begin
      tick();
      eg = ((c >= 1 && c <= XW) || c == XW + GC + 2) ? 4'b0001 : 4'b0000;
      ew = (c >= 2 && c <= XW + 1);
      ed = (c == XW + 1);
      runs++; if (grant !== eg) begin fails++; $display("FAIL single_grant c=%0d: got %b expected %b", c, grant, eg); end
      runs++; if (word_ack !== eg) begin fails++; $display("FAIL single_ack c=%0d: got %b expected %b", c, word_ack, eg); end
      runs++; if (write_en !== ew) begin fails++; $display("FAIL single_we c=%0d: got %b expected %b", c, write_en, ew); end
      runs++; if (pkt_done !== ed) begin fails++; $display("FAIL single_done c=%0d: got %b expected %b", c, pkt_done, ed); end
      runs++; if (pkt_count !== ((c >= XW + 1) ? 16'd1 : 16'd0)) begin fails++; $display("FAIL single_count c=%0d: got %0d", c, pkt_count); end
      if (ew) begin
        runs++; if (data_out !== 32'hA0 + 32'(c - 2)) begin fails++; $display("FAIL single_data c=%0d: got %h expected %h", c, data_out, 32'hA0 + 32'(c - 2)); end
      end
    end
  endtask

  task automatic test_rr_order();
    int order[$];
    int exp_order[5] = '{0, 1, 2, 3, 0};
    int writes, dones, src;
    logic [3:0] prev_g;
    do_reset();
    req = 4'hF; req_dest = 8'h00;
    prev_g = '0; writes = 0; dones = 0; src = 0;
    for (int c = 0; c < 120 && dones < 5; c++) begin
      tick();
      if (prev_g == 4'b0 && grant != 4'b0) begin
        for (int i = 0; i < NP; i++) if (grant[i]) src = i;
        order.push_back(src);
      end
      prev_g = grant;
      if (write_en) begin
        writes++;
        runs++; if (data_out[31:24] !== 8'(src)) begin fails++; $display("FAIL rr_data_src: got %0d expected %0d", data_out[31:24], src); end
      end
      if (pkt_done) begin
        dones++;
        runs++; if (writes !== XW) begin fails++; $display("FAIL rr_writes pkt=%0d: got %0d expected %0d", dones, writes, XW); end
        writes = 0;
        if (dones == 5) begin
          runs++; if (pkt_count !== 16'd5) begin fails++; $display("FAIL rr_count: got %0d expected 5", pkt_count); end
        end
      end
    end
    runs++; if (dones !== 5) begin fails++; $display("FAIL rr_timeout: got %0d packets expected 5", dones); end
    runs++; if (order.size() < 5) begin fails++; $display("FAIL rr_grants: got %0d grants expected 5", order.size()); end
    for (int k = 0; k < 5 && k < order.size(); k++) begin
      runs++; if (order[k] !== exp_order[k]) begin fails++; $display("FAIL rr_order k=%0d: got %0d expected %0d", k, order[k], exp_order[k]); end
    end
  endtask

  task automatic test_dest_filter();
    int seen2;
    do_reset();
    req = 4'b0110; req_dest = 8'b00_00_10_00;
    seen2 = 0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (grant == 4'b0100) seen2++;
      runs++; if ((grant & 4'b1011) !== 4'b0) begin fails++; $display("FAIL dest_grant c=%0d: got %b expected 0000 or 0100", c, grant); end
      runs++; if (word_ack[1] !== 1'b0) begin fails++; $display("FAIL dest_ack1 c=%0d: got %b expected 0", c, word_ack[1]); end
    end
    runs++; if (seen2 == 0) begin fails++; $display("FAIL dest_req2_served: got %0d grant cycles expected >0", seen2); end
    runs++; if (cur_src !== 2'd2) begin fails++; $display("FAIL dest_cur_src: got %0d expected 2", cur_src); end
  endtask

  task automatic test_full();
    do_reset();
    egress_full = 1'b1; req = 4'b0001; req_dest = 8'h00;
    for (int c = 1; c <= 20; c++) begin
      tick();
      runs++; if (grant !== 4'b0) begin fails++; $display("FAIL full_grant c=%0d: got %b expected 0000", c, grant); end
      runs++; if (write_en !== 1'b0) begin fails++; $display("FAIL full_we c=%0d: got %b expected 0", c, write_en); end
    end
    egress_full = 1'b0;
    tick();
    runs++; if (grant !== 4'b0001) begin fails++; $display("FAIL full_release_grant: got %b expected 0001", grant); end
    runs++; if (write_en !== 1'b0) begin fails++; $display("FAIL full_release_we21: got %b expected 0", write_en); end
    tick();
    runs++; if (write_en !== 1'b1) begin fails++; $display("FAIL full_release_we22: got %b expected 1", write_en); end
  endtask

  task automatic test_commit();
    int writes;
    do_reset();
    base[0] = 32'hB0; drive_data();
    req = 4'b0001; req_dest = 8'h00;
    writes = 0;
    for (int c = 1; c <= 15; c++) begin
      tick();
      if (write_en) writes++;
      runs++; if (grant !== ((c <= XW) ? 4'b0001 : 4'b0000)) begin fails++; $display("FAIL commit_grant c=%0d: got %b", c, grant); end
      runs++; if (pkt_done !== (c == XW + 1)) begin fails++; $display("FAIL commit_done c=%0d: got %b", c, pkt_done); end
      if (c >= 2 && c <= XW + 1) begin
        runs++; if (data_out !== 32'hB0 + 32'(c - 2)) begin fails++; $display("FAIL commit_data c=%0d: got %h expected %h", c, data_out, 32'hB0 + 32'(c - 2)); end
      end
      if (c == 4) begin
        req = 4'b0000; egress_full = 1'b1; req_dest = 8'hFF;
      end
    end
    runs++; if (writes !== XW) begin fails++; $display("FAIL commit_writes: got %0d expected %0d", writes, XW); end
    runs++; if (pkt_count !== 16'd1) begin fails++; $display("FAIL commit_count: got %0d expected 1", pkt_count); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 4'b0001; req_dest = 8'h00;
    for (int c = 1; c <= 4; c++) tick();
    runs++; if (write_en !== 1'b1) begin fails++; $display("FAIL rmid_we_before: got %b expected 1", write_en); end
    reset = 1'b1;
    tick();
    runs++; if (write_en !== 1'b0) begin fails++; $display("FAIL rmid_we: got %b expected 0", write_en); end
    runs++; if (grant !== 4'b0) begin fails++; $display("FAIL rmid_grant: got %b expected 0000", grant); end
    runs++; if (word_ack !== 4'b0) begin fails++; $display("FAIL rmid_ack: got %b expected 0000", word_ack); end
    runs++; if (pkt_count !== 16'd0) begin fails++; $display("FAIL rmid_count: got %0d expected 0", pkt_count); end
    reset = 1'b0; req = 4'hF;
    tick();
    runs++; if (grant !== 4'b0001) begin fails++; $display("FAIL rmid_first: got %b expected 0001", grant); end
    for (int c = 0; c < XW; c++) tick();
    runs++; if (pkt_done !== 1'b1 || pkt_count !== 16'd1) begin fails++; $display("FAIL rmid_pkt: got done=%b count=%0d expected done=1 count=1", pkt_done, pkt_count); end
    tick();
    reset = 1'b1; req = 4'b0010;
    tick();
    runs++; if (pkt_count !== 16'd0) begin fails++; $display("FAIL rgap_count: got %0d expected 0", pkt_count); end
    reset = 1'b0;
    tick();
    runs++; if (grant !== 4'b0010) begin fails++; $display("FAIL rgap_grant: got %b expected 0010", grant); end
  endtask

  task automatic test_random();
    int m_T, m_w, m_p0, m_last, m_idle_from, m_cnt, m_src, w;
    int mptr[4];
    logic [3:0] exp_g, elig;
    logic exp_we, exp_done, found;
    logic [31:0] exp_d;
    do_reset();
    for (int i = 0; i < NP; i++) begin
      base[i] = $urandom;
      mptr[i] = 0;
    end
    drive_data();
    m_T = -1000; m_w = 0; m_p0 = 0; m_last = NP - 1; m_idle_from = 0; m_cnt = 0; m_src = 0;
    for (int c = 0; c < 900; c++) begin
      exp_g    = (c >= m_T + 1 && c <= m_T + XW) ? 4'(1 << m_w) : 4'b0;
      exp_we   = (c >= m_T + 2 && c <= m_T + XW + 1);
      exp_done = (c == m_T + XW + 1);
      if (exp_done) m_cnt++;
      if (c == m_T + 1) m_src = m_w;
      exp_d = base[m_w] + 32'(m_p0 + c - m_T - 2);
      runs++; if (grant !== exp_g) begin fails++; $display("FAIL rnd_grant c=%0d: got %b expected %b", c, grant, exp_g); end
      runs++; if (word_ack !== exp_g) begin fails++; $display("FAIL rnd_ack c=%0d: got %b expected %b", c, word_ack, exp_g); end
      runs++; if (write_en !== exp_we) begin fails++; $display("FAIL rnd_we c=%0d: got %b expected %b", c, write_en, exp_we); end
      runs++; if (pkt_done !== exp_done) begin fails++; $display("FAIL rnd_done c=%0d: got %b expected %b", c, pkt_done, exp_done); end
      runs++; if (cur_src !== 2'(m_src)) begin fails++; $display("FAIL rnd_src c=%0d: got %0d expected %0d", c, cur_src, m_src); end
      runs++; if (pkt_count !== 16'(m_cnt)) begin fails++; $display("FAIL rnd_count c=%0d: got %0d expected %0d", c, pkt_count, m_cnt); end
      if (exp_we) begin
        runs++; if (data_out !== exp_d) begin fails++; $display("FAIL rnd_data c=%0d: got %h expected %h", c, data_out, exp_d); end
      end
      req = 4'($urandom);
      for (int i = 0; i < NP; i++)
        req_dest[2*i +: 2] = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'(PID);
      egress_full = ($urandom_range(0, 4) == 0);
      if (c >= m_idle_from && !egress_full) begin
        for (int i = 0; i < NP; i++) elig[i] = req[i] && (req_dest[2*i +: 2] == 2'(PID));
        found = 1'b0;
        for (int k = 1; k <= NP; k++) begin
          w = (m_last + k) % NP;
          if (!found && elig[w]) begin
            found = 1'b1;
            m_T = c; m_w = w; m_p0 = mptr[w]; mptr[w] += XW;
            m_last = w; m_idle_from = c + XW + GC + 1;
          end
        end
      end
      tick();
    end
  endtask

  task automatic test_wrap();
    do_reset();
    force dut.pkt_count_q = 16'hFFFF;
    tick();
    release dut.pkt_count_q;
    runs++; if (pkt_count !== 16'hFFFF) begin fails++; $display("FAIL wrap_preload: got %h expected ffff", pkt_count); end
    req = 4'b0001; req_dest = 8'h00;
    for (int c = 1; c <= XW + 1; c++) begin
      tick();
      if (c <= XW) begin
        runs++; if (pkt_count !== 16'hFFFF) begin fails++; $display("FAIL wrap_hold c=%0d: got %h expected ffff", c, pkt_count); end
      end else begin
        runs++; if (pkt_done !== 1'b1) begin fails++; $display("FAIL wrap_done: got %b expected 1", pkt_done); end
        runs++; if (pkt_count !== 16'h0000) begin fails++; $display("FAIL wrap_count: got %h expected 0000", pkt_count); end
      end
    end
  endtask

  initial begin
    reset = 1'b1; req = '0; req_dest = '0; egress_full = 1'b0; data_in = '0; ack_s = '0;
    for (int i = 0; i < NP; i++) begin
      wptr[i] = 0;
      base[i] = '0;
    end
    test_reset();
    test_single();
    test_rr_order();
    test_dest_filter();
    test_full();
    test_commit();
    test_reset_mid();
    test_random();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", runs, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1);
  end

endmodule
